// File: rtl/main_memory_arbiter.sv
// -----------------------------------------------------------------------------
// main_memory_arbiter
//
// Shares the single line-granular main memory wrapper between two requesters:
// port 0 (instruction cache) and port 1 (data cache). One transaction is in
// flight at a time. When both ports request in the same IDLE cycle they are
// granted round-robin.
//
// Every memory-side signal comes straight from a register. This lets the
// wrapper sample READY in a single cycle and see its one-cycle
// request_finish acknowledged in the same cycle.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   pN_read_req/pN_write_req line request, held high until pN_done
//   pN_addr, pN_wdata        line byte address / write line, stable while requesting
//   pN_done                  one-cycle completion pulse
//   pN_rdata                 last line read by port N (held between reads)
//   pN_busy                  port N currently owns the memory
//   mem_read_request/mem_write_request/mem_addr/mem_write_data  to wrapper
//   mem_request_finish/mem_read_data                           from wrapper
// -----------------------------------------------------------------------------
module main_memory_arbiter #(
    parameter int LINE_ADDR_LEN = 3,
    localparam int LW = 32 * (1 << LINE_ADDR_LEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_read_req,
    input  logic          p0_write_req,
    input  logic [31:0]   p0_addr,
    input  logic [LW-1:0] p0_wdata,
    output logic          p0_done,
    output logic [LW-1:0] p0_rdata,
    output logic          p0_busy,
    input  logic          p1_read_req,
    input  logic          p1_write_req,
    input  logic [31:0]   p1_addr,
    input  logic [LW-1:0] p1_wdata,
    output logic          p1_done,
    output logic [LW-1:0] p1_rdata,
    output logic          p1_busy,
    output logic          mem_read_request,
    output logic          mem_write_request,
    output logic [31:0]   mem_addr,
    output logic [LW-1:0] mem_write_data,
    input  logic          mem_request_finish,
    input  logic [LW-1:0] mem_read_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        state_reg;
    state_t        state_next;

    logic          owner_reg;
    logic          rr_last_reg;
    logic          op_write_reg;
    logic          mem_rd_reg;
    logic          mem_wr_reg;
    logic [31:0]   mem_addr_reg;
    logic [LW-1:0] mem_wdata_reg;
    logic [1:0]    done_reg;
    logic [LW-1:0] rdata_reg [2];

    // Per-port request views so the grant logic can index by port number.
    logic [1:0]    req_rd;
    logic [1:0]    req_any;
    logic [31:0]   req_addr  [2];
    logic [LW-1:0] req_wdata [2];

    logic          grant_valid;
    logic          grant_port;
    logic [1:0]    busy_vec;

    assign req_rd       = {p1_read_req, p0_read_req};
    assign req_any      = {p1_read_req | p1_write_req, p0_read_req | p0_write_req};
    assign req_addr[0]  = p0_addr;
    assign req_addr[1]  = p1_addr;
    assign req_wdata[0] = p0_wdata;
    assign req_wdata[1] = p1_wdata;

    // ---------------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            owner_reg     <= 1'b0;
            rr_last_reg   <= 1'b1;     // port 0 wins the first tie
            op_write_reg  <= 1'b0;
            mem_rd_reg    <= 1'b0;
            mem_wr_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            done_reg      <= '0;
            rdata_reg[0]  <= '0;
            rdata_reg[1]  <= '0;
        end else begin
            state_reg <= state_next;
            done_reg  <= '0;           // done is a single-cycle pulse
            case (state_reg)
                S_IDLE: begin
                    if (grant_valid) begin
                        owner_reg    <= grant_port;
                        rr_last_reg  <= grant_port;
                        // A port raising both requests is served as a read.
                        op_write_reg <= ~req_rd[grant_port];
                        mem_addr_reg <= req_addr[grant_port];
                        if (!req_rd[grant_port]) begin
                            mem_wdata_reg <= req_wdata[grant_port];
                        end
                        mem_rd_reg   <= req_rd[grant_port];
                        mem_wr_reg   <= ~req_rd[grant_port];
                    end
                end
                S_BUSY: begin
                    if (mem_request_finish) begin
                        // Dropping the request here keeps it low while the
                        // wrapper sits in READY, so it cannot re-trigger.
                        mem_rd_reg          <= 1'b0;
                        mem_wr_reg          <= 1'b0;
                        done_reg[owner_reg] <= 1'b1;
                        if (!op_write_reg) begin
                            rdata_reg[owner_reg] <= mem_read_data;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Next state and grant selection
    // ---------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        grant_valid = 1'b0;
        grant_port  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (req_any != 2'b00) begin
                    grant_valid = 1'b1;
                    grant_port  = (req_any == 2'b11) ? ~rr_last_reg : req_any[1];
                    state_next  = S_BUSY;
                end
            end
            S_BUSY: begin
                if (mem_request_finish) begin
                    state_next = S_RESP;
                end
            end
            S_RESP:  state_next = S_IDLE;   // requests ignored for this cycle
            default: state_next = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    always_comb begin
        busy_vec = '0;
        if (state_reg != S_IDLE) begin
            busy_vec[owner_reg] = 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            if (gi == 0) begin : g_p0
                assign p0_done  = done_reg[gi];
                assign p0_rdata = rdata_reg[gi];
                assign p0_busy  = busy_vec[gi];
            end else begin : g_p1
                assign p1_done  = done_reg[gi];
                assign p1_rdata = rdata_reg[gi];
                assign p1_busy  = busy_vec[gi];
            end
        end
    endgenerate

    assign mem_read_request  = mem_rd_reg;
    assign mem_write_request = mem_wr_reg;
    assign mem_addr          = mem_addr_reg;
    assign mem_write_data    = mem_wdata_reg;

endmodule

// File: tb/tb_main_memory_arbiter.sv
// -----------------------------------------------------------------------------
// tb_main_memory_arbiter
//
// Directed bench for main_memory_arbiter. A small wrapper model asserts
// request_finish in the 20th cycle a request is held. It stores written lines.
// Its line contents after reset are word j of line L = L*32 + 4*j, so each
// word's value equals its byte address.
// -----------------------------------------------------------------------------
module tb_main_memory_arbiter;

    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          p0_read_req = 1'b0, p0_write_req = 1'b0;
    logic          p1_read_req = 1'b0, p1_write_req = 1'b0;
    logic [31:0]   p0_addr = '0, p1_addr = '0;
    logic [LW-1:0] p0_wdata = '0, p1_wdata = '0;
    logic          p0_done, p1_done, p0_busy, p1_busy;
    logic [LW-1:0] p0_rdata, p1_rdata;
    logic          mem_read_request, mem_write_request;
    logic [31:0]   mem_addr;
    logic [LW-1:0] mem_write_data;
    logic          mem_request_finish;
    logic [LW-1:0] mem_read_data;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    main_memory_arbiter #(.LINE_ADDR_LEN(3)) dut (
        .clk               (clk),
        .rst               (rst),
        .p0_read_req       (p0_read_req),
        .p0_write_req      (p0_write_req),
        .p0_addr           (p0_addr),
        .p0_wdata          (p0_wdata),
        .p0_done           (p0_done),
        .p0_rdata          (p0_rdata),
        .p0_busy           (p0_busy),
        .p1_read_req       (p1_read_req),
        .p1_write_req      (p1_write_req),
        .p1_addr           (p1_addr),
        .p1_wdata          (p1_wdata),
        .p1_done           (p1_done),
        .p1_rdata          (p1_rdata),
        .p1_busy           (p1_busy),
        .mem_read_request  (mem_read_request),
        .mem_write_request (mem_write_request),
        .mem_addr          (mem_addr),
        .mem_write_data    (mem_write_data),
        .mem_request_finish(mem_request_finish),
        .mem_read_data     (mem_read_data)
    );

    // ---------------- wrapper model ----------------
    logic [LW-1:0] mem_line [64];
    int            mcnt;
    logic          mem_req_any;

    assign mem_req_any        = mem_read_request | mem_write_request;
    assign mem_request_finish = mem_req_any && (mcnt == 19);
    assign mem_read_data      = mem_line[mem_addr[10:5]];

    always @(posedge clk) begin
        if (rst) begin
            mcnt <= 0;
            for (int l = 0; l < 64; l++) begin
                for (int j = 0; j < 8; j++) begin
                    mem_line[l][32*j +: 32] <= 32'(l * 32 + 4 * j);
                end
            end
        end else if (mem_req_any && !mem_request_finish) begin
            mcnt <= mcnt + 1;
        end else begin
            mcnt <= 0;
            if (mem_request_finish && mem_write_request) begin
                mem_line[mem_addr[10:5]] <= mem_write_data;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] line_at(input logic [31:0] a);
        logic [LW-1:0] r;
        for (int j = 0; j < 8; j++) r[32*j +: 32] = a + 32'(4 * j);
        return r;
    endfunction

    function automatic logic [LW-1:0] all_outs();
        return LW'({p0_done, p1_done, p0_busy, p1_busy,
                    mem_read_request, mem_write_request, mem_addr})
               | p0_rdata | p1_rdata | mem_write_data;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_req(input int port, input bit rd, input bit wr,
                           input logic [31:0] a, input logic [LW-1:0] wd);
        if (port == 0) begin
            p0_read_req = rd; p0_write_req = wr; p0_addr = a; p0_wdata = wd;
        end else begin
            p1_read_req = rd; p1_write_req = wr; p1_addr = a; p1_wdata = wd;
        end
    endtask

    // One uncontended transaction: raise the request in cycle t, watch until
    // that port's done, then drop the request.
    task automatic do_txn(input string tag, input int port, input bit rd, input bit wr,
                          input logic [31:0] a, input logic [LW-1:0] wd,
                          output int lat, output int rdc, output int wrc,
                          output logic [LW-1:0] rdata);
        bit other_done;
        lat = -1; rdc = 0; wrc = 0; rdata = '0; other_done = 1'b0;
        set_req(port, rd, wr, a, wd);
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (k == 1) check({tag, " mem_addr"}, LW'(mem_addr), LW'(a));
            if (mem_read_request)  rdc++;
            if (mem_write_request) wrc++;
            if ((port == 0 ? p1_done : p0_done)) other_done = 1'b1;
            if ((port == 0 ? p0_done : p1_done)) begin
                lat   = k;
                rdata = (port == 0) ? p0_rdata : p1_rdata;
                break;
            end
        end
        set_req(port, 1'b0, 1'b0, a, wd);
        check({tag, " other_done"}, LW'(other_done), LW'(0));
        tick();
        check({tag, " done_width"}, LW'(port == 0 ? p0_done : p1_done), LW'(0));
        $display("txn %s: port %0d addr %h latency %0d rd_cycles %0d wr_cycles %0d",
                 tag, port, a, lat, rdc, wrc);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int            lat, rdc, wrc;
        logic [LW-1:0] rd_line, wline;
        int            t_d0, t_d1, t_p1m, fin, dbl, ndone, order;
        bit            prev0, prev1;

        // Reset state
        do_reset();
        check("reset outputs", all_outs(), '0);
        check("reset idle", LW'({p0_busy, p1_busy}), LW'(0));

        // Uncontended p0 read of 0x40
        do_txn("p0_rd40", 0, 1'b1, 1'b0, 32'h40, '0, lat, rdc, wrc, rd_line);
        check("p0_rd40 latency", LW'(lat), LW'(21));
        check("p0_rd40 rd_cycles", LW'(rdc), LW'(20));
        check("p0_rd40 wr_cycles", LW'(wrc), LW'(0));
        check("p0_rd40 rdata", rd_line, line_at(32'h40));
        check("p0_rd40 p1_rdata", p1_rdata, '0);
        check("p0_rd40 rdata held", p0_rdata, line_at(32'h40));

        // p1 write of 0x100 with words 1..8, then read back
        for (int j = 0; j < 8; j++) wline[32*j +: 32] = 32'(j + 1);
        do_txn("p1_wr100", 1, 1'b0, 1'b1, 32'h100, wline, lat, rdc, wrc, rd_line);
        check("p1_wr100 latency", LW'(lat), LW'(21));
        check("p1_wr100 wr_cycles", LW'(wrc), LW'(20));
        check("p1_wr100 rd_cycles", LW'(rdc), LW'(0));
        check("p1_wr100 mem_wdata", mem_write_data, wline);
        do_txn("p1_rd100", 1, 1'b1, 1'b0, 32'h100, '0, lat, rdc, wrc, rd_line);
        check("p1_rd100 latency", LW'(lat), LW'(21));
        check("p1_rd100 rdata", rd_line, wline);
        check("p1_rd100 p0_rdata", p0_rdata, line_at(32'h40));

        // Simultaneous reads: port 0 first, port 1 two cycles after p0_done
        do_reset();
        t_d0 = -1; t_d1 = -1; t_p1m = -1;
        set_req(0, 1'b1, 1'b0, 32'h40, '0);
        set_req(1, 1'b1, 1'b0, 32'h60, '0);
        for (int k = 1; k <= 80 && t_d1 < 0; k++) begin
            tick();
            if (p0_done && t_d0 < 0) begin t_d0 = k; p0_read_req = 1'b0; end
            if (p1_busy && mem_read_request && t_p1m < 0) t_p1m = k;
            if (p1_done) begin t_d1 = k; p1_read_req = 1'b0; end
        end
        p0_read_req = 1'b0; p1_read_req = 1'b0;
        check("contend p0_done", LW'(t_d0), LW'(21));
        check("contend p1_mem_start", LW'(t_p1m), LW'(23));
        check("contend p1_done", LW'(t_d1), LW'(43));
        check("contend p1_rdata", p1_rdata, line_at(32'h60));
        $display("txn contend: p0_done %0d p1_mem_start %0d p1_done %0d", t_d0, t_p1m, t_d1);
        tick();

        // Continuous contention for four transactions
        do_reset();
        fin = 0; dbl = 0; ndone = 0; order = 0; prev0 = 1'b0; prev1 = 1'b0;
        set_req(0, 1'b1, 1'b0, 32'h40, '0);
        set_req(1, 1'b1, 1'b0, 32'h80, '0);
        for (int k = 1; k <= 200 && ndone < 4; k++) begin
            tick();
            if (mem_request_finish) fin++;
            if ((p0_done && prev0) || (p1_done && prev1)) dbl++;
            if (p0_done) begin order = order * 10 + 0; ndone++; end
            if (p1_done) begin order = order * 10 + 1; ndone++; end
            prev0 = p0_done; prev1 = p1_done;
        end
        p0_read_req = 1'b0; p1_read_req = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (mem_request_finish) fin++;
            if ((p0_done && prev0) || (p1_done && prev1)) dbl++;
            prev0 = p0_done; prev1 = p1_done;
        end
        check("rr dones", LW'(ndone), LW'(4));
        check("rr order", LW'(order), LW'(101));   // digits 0,1,0,1
        check("rr finishes", LW'(fin), LW'(4));
        check("rr wide_done", LW'(dbl), LW'(0));
        $display("txn round_robin: order %04d finishes %0d", order, fin);

        // Reset in cycle 12 of a p0 read aborts it without a done pulse
        do_reset();
        set_req(0, 1'b1, 1'b0, 32'h40, '0);
        for (int k = 1; k <= 11; k++) tick();
        check("abort busy before rst", LW'(p0_busy), LW'(1));
        rst = 1'b1;
        p0_read_req = 1'b0;
        tick();
        check("abort outputs", all_outs(), '0);
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (p0_done) ndone++;
        end
        check("abort no_done", LW'(ndone), LW'(0));
        $display("txn abort: p0 read reset mid-flight");
        do_txn("p1_rdC0", 1, 1'b1, 1'b0, 32'hC0, '0, lat, rdc, wrc, rd_line);
        check("p1_rdC0 latency", LW'(lat), LW'(21));
        check("p1_rdC0 rdata", rd_line, line_at(32'hC0));

        // Read and write both high on one port: served as a read
        do_txn("p0_rdwr20", 0, 1'b1, 1'b1, 32'h20, {LW{1'b1}}, lat, rdc, wrc, rd_line);
        check("p0_rdwr20 wr_cycles", LW'(wrc), LW'(0));
        check("p0_rdwr20 latency", LW'(lat), LW'(21));
        check("p0_rdwr20 rdata", rd_line, line_at(32'h20));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/main_memory_arbiter.md
Name: main_memory_arbiter

Overview:
- Two-requester arbiter in front of MainMemoryWrapper; shares the single line-granular main memory between the instruction cache (port 0) and the data cache (port 1).
- Round-robin arbitration; one transaction in flight at a time.
- Registers all memory-side request signals so the wrapper's one-cycle READY sampling and 1-cycle request_finish pulse are met exactly.
- Returns read lines and a one-cycle done pulse to the granted requester.

Parameters:
- LINE_ADDR_LEN, 3, log2 of words per line; line width LW = 32*(1<<LINE_ADDR_LEN) bits (256 at default).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- p0_read_req, p1_read_req  in  1 each  read-line request; held high until the port's done.
- p0_write_req, p1_write_req  in  1 each  write-line request; held high until the port's done.
- p0_addr, p1_addr  in  32 each  line byte address; stable while request high.
- p0_wdata, p1_wdata  in  LW each  write line; stable while request high.
- p0_done, p1_done  out  1 each  one-cycle completion pulse.
- p0_rdata, p1_rdata  out  LW each  read line; valid in the done cycle, held until that port's next read done.
- p0_busy, p1_busy  out  1 each  high while that port owns memory (BUSY or RESP).
- mem_read_request, mem_write_request  out  1 each  to wrapper.
- mem_addr  out  32  to wrapper.
- mem_write_data  out  LW  to wrapper.
- mem_request_finish  in  1  from wrapper.
- mem_read_data  in  LW  from wrapper.

Behaviour:
- Reset: all outputs 0, state IDLE, rr_last=1 (port 0 wins first tie), owner=0, op=read.
- Reset mid-transaction: arbiter returns to IDLE immediately. The wrapper shares rst; no done pulse is issued for the aborted transaction.
- States: IDLE -> BUSY -> RESP -> IDLE.
- IDLE:
  - req_n = pN_read_req | pN_write_req.
  - If exactly one port requests, grant it.
  - If both request, grant !rr_last.
  - On grant, at the clock edge: owner<=n, rr_last<=n, op<=read if pN_read_req else write (read wins if both high on one port; illegal but defined).
  - Also at the grant edge: mem_addr<=pN_addr, mem_write_data<=pN_wdata (write only), assert exactly one of mem_read_request/mem_write_request, go to BUSY.
  - With no request, mem outputs stay 0.
- BUSY:
  - Hold mem request, addr and write data constant.
  - Owner's addr/wdata are not resampled.
  - On mem_request_finish=1, at that edge: drop both mem requests, latch mem_read_data into pN_rdata (read only), set pN_done=1, go to RESP.
- RESP:
  - Lasts exactly one cycle; done high only in this cycle, then 0.
  - Requests (including the owner's still-high one) are ignored.
  - Next state is IDLE.
- Timing:
  - Mem request is low in the cycle after finish, when the wrapper is in READY, so it never re-triggers.
  - The gap between back-to-back transactions is at least 2 cycles.
- Latency: uncontended request first high in cycle t -> mem request high t+1 -> mem_request_finish t+20 -> pN_done t+21. Reads and writes are identical.
- Fairness: under continuous contention grants alternate 0,1,0,1. No port waits more than one transaction.
- The non-owner's request is only observed in IDLE. Its done stays 0, and its rdata is untouched by the owner's transaction.
- mem_write_data holds its last value during reads (don't-care to the wrapper).
- busy: pN_busy = (state!=IDLE) & (owner==n).

Test Plan:
- Reset then p0_read_req at cycle 5, addr 0x40 -> mem_read_request high from cycle 6 with mem_addr=0x40. p0_done pulses in cycle 26 only, with p0_rdata equal to the 8 words at 0x40..0x5C. p1 outputs stay 0.
- p1_write_req at cycle 5, addr 0x100, wdata words 1..8 -> mem_write_request cycles 6..25, p1_done in cycle 26. A follow-up p1 read of 0x100 returns words 1..8.
- p0 and p1 reads both raised in the same cycle after reset -> port 0 served first (done at t+21). Port 1's mem request starts exactly 2 cycles after p0_done, and p1_done follows 20 cycles later.
- Both ports held continuously requesting for 4 transactions -> grant order 0,1,0,1. Each done pulse lasts exactly 1 cycle, and no wrapper re-trigger occurs: exactly 4 finishes.
- rst asserted in cycle 12 of a p0 read -> all outputs 0 next cycle, no p0_done. A p1 read issued afterwards completes normally with done 21 cycles after request.
- p0_read_req and p0_write_req both high -> treated as read: mem_write_request never asserts, p0_done arrives with read data.
